ft_tx_arbiter: RTL and testbench

FT_TX_ARBITER -- requirements
Module: ft_tx_arbiter

---
 rtl/ft_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ft_tx_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_tx_arbiter.sv
// FT232H transmit arbiter: three byte requesters share the FT232H write path, plus send-immediate flush.
// Optional build macro FT_TX_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed priority.
module ft_tx_arbiter #(
   parameter int unsigned FLUSH_IDLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic       req1_last,
   output logic       req1_ready,
   input  logic       req2_valid,
   input  logic [7:0] req2_data,
   input  logic       req2_last,
   output logic       req2_ready,
   input  logic       rx_busy,
   input  logic       ft_txe_n,
   output logic [7:0] ft_data,
   output logic       ft_wr_n,
   output logic       ft_siwu_n,
   output logic [2:0] grant,
   output logic       tx_active
);

   localparam int unsigned NREQ  = 3;
   localparam int unsigned CNT_W = 8;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] FLUSH_PRE = CNT_W'(FLUSH_IDLE - 1);

   logic [0:0]       state_q, state_d;
   logic [NREQ-1:0]  grant_q, grant_d;
   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
   logic             pend_q, pend_d;
   logic             siwu_n_q, siwu_n_d;

   logic [NREQ-1:0]  valid_v, last_v, ready_v, xfer_v, win;
   logic             xfer, xfer_last, flush;

   assign valid_v = {req2_valid, req1_valid, req0_valid};
   assign last_v  = {req2_last, req1_last, req0_last};

   // Ready is combinational so a byte can move every cycle the FIFO and bus allow.
   assign ready_v   = (state_q == ST_SEND) ? (grant_q & {NREQ{~ft_txe_n & ~rx_busy}}) : '0;
   assign xfer_v    = ready_v & valid_v;
   assign xfer      = |xfer_v;
   assign xfer_last = |(xfer_v & last_v);

   assign req0_ready = ready_v[0];
   assign req1_ready = ready_v[1];
   assign req2_ready = ready_v[2];
   assign ft_wr_n    = ~xfer;
   assign ft_siwu_n  = siwu_n_q;
   assign grant      = grant_q;
   assign tx_active  = (state_q == ST_SEND);

   // Bus data follows the owner; parked at zero when nobody owns the path.
   always_comb begin
      ft_data = 8'h00;
      if (grant_q[0])      ft_data = req0_data;
      else if (grant_q[1]) ft_data = req1_data;
      else if (grant_q[2]) ft_data = req2_data;
   end

`ifdef FT_TX_ROUND_ROBIN_EN
   logic [1:0] ptr_q, ptr_d;
   logic [2:0] rr_sum;
   logic [1:0] rr_idx;

   // First valid requester at or after the pointer, wrapping modulo 3.
   always_comb begin
      win    = '0;
      rr_sum = '0;
      rr_idx = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         rr_sum = 3'(ptr_q) + 3'(i);
         if (rr_sum >= 3'd3) rr_sum = rr_sum - 3'd3;
         rr_idx = 2'(rr_sum);
         if ((win == '0) && valid_v[rr_idx]) win[rr_idx] = 1'b1;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if ((state_q == ST_SEND) && xfer_last) begin
         case (grant_q)
            3'b001:  ptr_d = 2'd1;
            3'b010:  ptr_d = 2'd2;
            3'b100:  ptr_d = 2'd0;
            default: ptr_d = ptr_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
`else
   always_comb begin
      win = '0;
      if (valid_v[0])      win = 3'b001;
      else if (valid_v[1]) win = 3'b010;
      else if (valid_v[2]) win = 3'b100;
   end
`endif

   // Next state: grant is taken in IDLE, released on the last-byte transfer.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      case (state_q)
         ST_IDLE: begin
            if (!rx_busy && (valid_v != '0)) begin
               state_d = ST_SEND;
               grant_d = win;
            end
         end
         ST_SEND: begin
            if (xfer_last) begin
               state_d = ST_IDLE;
               grant_d = '0;
            end
         end
      endcase
   end

   // Flush: pulse once the line has been quiet FLUSH_IDLE cycles after sending data.
   always_comb begin
      flush      = pend_q & ~xfer & (idle_cnt_q == FLUSH_PRE);
      idle_cnt_d = idle_cnt_q;
      if (xfer)                     idle_cnt_d = '0;
      else if (idle_cnt_q != CNT_MAX) idle_cnt_d = idle_cnt_q + CNT_W'(1);
      pend_d   = xfer | (pend_q & ~flush);
      siwu_n_d = ~flush;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         idle_cnt_q <= '0;
         pend_q     <= 1'b0;
         siwu_n_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         idle_cnt_q <= idle_cnt_d;
         pend_q     <= pend_d;
         siwu_n_q   <= siwu_n_d;
      end
   end

endmodule

// File: tb/tb_ft_tx_arbiter.sv
// Self-checking bench for ft_tx_arbiter: directed cases plus randomized traffic against a behavioural model.
module tb_ft_tx_arbiter;

   localparam int unsigned FLUSH = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] vld = '0;
   logic [2:0] lst = '0;
   logic [7:0] dat [3];
   logic       rx_busy = 1'b0;
   logic       ft_txe_n = 1'b0;
   logic       rdy0, rdy1, rdy2;
   logic [7:0] ft_data;
   logic       ft_wr_n, ft_siwu_n, tx_active;
   logic [2:0] grant;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   ft_tx_arbiter #(.FLUSH_IDLE(FLUSH)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(vld[0]), .req0_data(dat[0]), .req0_last(lst[0]), .req0_ready(rdy0),
      .req1_valid(vld[1]), .req1_data(dat[1]), .req1_last(lst[1]), .req1_ready(rdy1),
      .req2_valid(vld[2]), .req2_data(dat[2]), .req2_last(lst[2]), .req2_ready(rdy2),
      .rx_busy(rx_busy), .ft_txe_n(ft_txe_n),
      .ft_data(ft_data), .ft_wr_n(ft_wr_n), .ft_siwu_n(ft_siwu_n),
      .grant(grant), .tx_active(tx_active)
   );

   // Behavioural model: owner index (-1 = none), rotation pointer, edge count of last transfer.
   int      owner = -1;
   int      ptr = 0;
   longint  cyc = 0;
   longint  last_tx = 0;
   bit      pend = 1'b0;
   bit      siwu_e = 1'b1;

   function automatic logic [2:0] m_grant();
      return (owner < 0) ? 3'b000 : 3'(1 << owner);
   endfunction

   function automatic logic m_rdy(input int n);
      return (owner == n) && !ft_txe_n && !rx_busy;
   endfunction

   function automatic logic m_xfer();
      if (owner < 0) return 1'b0;
      return m_rdy(owner) && vld[owner[1:0]];
   endfunction

   function automatic logic [7:0] m_data();
      return (owner < 0) ? 8'h00 : dat[owner[1:0]];
   endfunction

   function automatic int pick();
`ifdef FT_TX_ROUND_ROBIN_EN
      for (int k = 0; k < 3; k++) begin
         int idx;
         idx = (ptr + k) % 3;
         if (vld[idx[1:0]]) return idx;
      end
`else
      for (int k = 0; k < 3; k++)
         if (vld[k[1:0]]) return k;
`endif
      return -1;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         owner  <= -1;
         ptr    <= 0;
         pend   <= 1'b0;
         siwu_e <= 1'b1;
         cyc    <= 0;
      end else begin
         cyc <= cyc + 1;
         if (m_xfer()) begin
            last_tx <= cyc + 1;
            pend    <= 1'b1;
            siwu_e  <= 1'b1;
         end else if (pend && ((cyc + 1 - last_tx) == longint'(FLUSH))) begin
            pend    <= 1'b0;
            siwu_e  <= 1'b0;
         end else begin
            siwu_e  <= 1'b1;
         end
         if (owner < 0) begin
            if (!rx_busy && (vld != 3'b000)) owner <= pick();
         end else if (m_xfer() && lst[owner[1:0]]) begin
            owner <= -1;
            ptr   <= (owner + 1) % 3;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("grant",     32'(grant),     32'(m_grant()));
         chk("ready0",    32'(rdy0),      32'(m_rdy(0)));
         chk("ready1",    32'(rdy1),      32'(m_rdy(1)));
         chk("ready2",    32'(rdy2),      32'(m_rdy(2)));
         chk("wr_n",      32'(ft_wr_n),   32'(!m_xfer()));
         chk("data",      32'(ft_data),   32'(m_data()));
         chk("siwu_n",    32'(ft_siwu_n), 32'(siwu_e));
         chk("tx_active", 32'(tx_active), 32'(owner >= 0));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      vld = '0; lst = '0; rx_busy = 1'b0; ft_txe_n = 1'b0;
      dat[0] = 8'h00; dat[1] = 8'h00; dat[2] = 8'h00;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   int q3[$];
   int exp3[4];
   int lows, low_pos;

   initial begin
      quiet();
      rst = 1'b1;
      step();
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_wr_n",  32'(ft_wr_n), 32'h1);
      chk("rst_siwu",  32'(ft_siwu_n), 32'h1);
      chk("rst_data",  32'(ft_data), 32'h0);
      chk("rst_ready", 32'({rdy2, rdy1, rdy0}), 32'h0);
      step();
      rst = 1'b0;

      // Case 1: four-byte packet from req0.
      vld[0] = 1'b1; dat[0] = 8'hA1; lst[0] = 1'b0;
      @(negedge clk);
      chk("c1_lat_grant", 32'(grant), 32'h0);
      step();
      for (int b = 0; b < 4; b++) begin
         dat[0] = 8'hA1 + 8'(b);
         lst[0] = (b == 3);
         @(negedge clk);
         chk("c1_grant", 32'(grant), 32'h1);
         chk("c1_wr_n",  32'(ft_wr_n), 32'h0);
         chk("c1_data",  32'(ft_data), 32'(8'hA1 + 8'(b)));
         step();
      end
      quiet();
      @(negedge clk);
      chk("c1_end_grant", 32'(grant), 32'h0);
      chk("c1_end_active", 32'(tx_active), 32'h0);
      step();

      // Case 2: FIFO full for three cycles after the second byte.
      vld[0] = 1'b1; dat[0] = 8'hB1;
      step();
      @(negedge clk); chk("c2_b1_wr", 32'(ft_wr_n), 32'h0);
      step();
      dat[0] = 8'hB2;
      @(negedge clk); chk("c2_b2_wr", 32'(ft_wr_n), 32'h0);
      step();
      dat[0] = 8'hB3; ft_txe_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("c2_stall_wr", 32'(ft_wr_n), 32'h1);
         chk("c2_stall_grant", 32'(grant), 32'h1);
         step();
      end
      ft_txe_n = 1'b0;
      @(negedge clk);
      chk("c2_b3_wr", 32'(ft_wr_n), 32'h0);
      chk("c2_b3_data", 32'(ft_data), 32'hB3);
      step();
      dat[0] = 8'hB4; lst[0] = 1'b1;
      step();
      quiet();

      // Case 3: all three requesters streaming single-byte packets.
      do_reset();
      vld = 3'b111; lst = 3'b111;
      dat[0] = 8'h10; dat[1] = 8'h11; dat[2] = 8'h12;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (grant != 3'b000) q3.push_back(int'(grant));
         step();
      end
`ifdef FT_TX_ROUND_ROBIN_EN
      exp3 = '{1, 2, 4, 1};
`else
      exp3 = '{1, 1, 1, 1};
`endif
      chk("c3_count_ge4", 32'(q3.size() >= 4), 32'h1);
      for (int i = 0; i < 4; i++) chk("c3_order", 32'(q3[i]), 32'(exp3[i]));
      quiet();
      step();

      // Case 4: receive path busy blocks arbitration.
      do_reset();
      rx_busy = 1'b1; vld[1] = 1'b1; dat[1] = 8'h44;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); chk("c4_busy_grant", 32'(grant), 32'h0);
         step();
      end
      rx_busy = 1'b0;
      @(negedge clk); chk("c4_release_grant", 32'(grant), 32'h0);
      step();
      lst[1] = 1'b1;
      @(negedge clk);
      chk("c4_grant", 32'(grant), 32'h2);
      chk("c4_wr", 32'(ft_wr_n), 32'h0);
      step();
      quiet();

      // Case 5: one byte, then 16 quiet cycles and a single flush pulse.
      do_reset();
      vld[0] = 1'b1; lst[0] = 1'b1; dat[0] = 8'hC5;
      step();
      @(negedge clk); chk("c5_xfer", 32'(ft_wr_n), 32'h0);
      step();
      quiet();
      lows = 0; low_pos = 0;
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         if (ft_siwu_n == 1'b0) begin lows++; low_pos = k; end
         step();
      end
      chk("c5_pulse_count", 32'(lows), 32'h1);
      chk("c5_pulse_pos", 32'(low_pos), 32'(FLUSH + 1));

      // Case 7: a transfer landing on the flush cycle suppresses the pulse.
      do_reset();
      vld[1] = 1'b1; lst[1] = 1'b1; dat[1] = 8'h77;
      step();
      step();
      quiet();
      for (int k = 1; k <= 20; k++) begin
         vld[1] = (k >= 14 && k <= 16); lst[1] = 1'b1; dat[1] = 8'h78;
         ft_txe_n = (k == 15);
         @(negedge clk);
         if (k == 16) chk("c7_xfer", 32'(ft_wr_n), 32'h0);
         if (k == 17) chk("c7_no_pulse", 32'(ft_siwu_n), 32'h1);
         step();
      end
      quiet();

      // Case 6: reset in the middle of a req2 packet.
      do_reset();
      vld[2] = 1'b1; lst[2] = 1'b0; dat[2] = 8'hD0;
      step();
      @(negedge clk); chk("c6_grant", 32'(grant), 32'h4);
      step();
      dat[2] = 8'hD1;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("c6_rst_grant", 32'(grant), 32'h0);
      chk("c6_rst_wr", 32'(ft_wr_n), 32'h1);
      chk("c6_rst_ready", 32'(rdy2), 32'h0);
      chk("c6_rst_data", 32'(ft_data), 32'h0);
      step();
      lst[2] = 1'b1;
      @(negedge clk); chk("c6_regrant", 32'(grant), 32'h4);
      step();
      quiet();

      // Randomized traffic with periodic quiet windows so flush pulses occur.
      for (int i = 0; i < 4000; i++) begin
         bit hush;
         hush     = (i % 250) >= 200;
         rst      = ($urandom_range(0, 299) == 0);
         vld[0]   = !hush && ($urandom_range(0, 9) < 6);
         vld[1]   = !hush && ($urandom_range(0, 9) < 6);
         vld[2]   = !hush && ($urandom_range(0, 9) < 6);
         lst      = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
         dat[0]   = 8'($urandom);
         dat[1]   = 8'($urandom);
         dat[2]   = 8'($urandom);
         ft_txe_n = ($urandom_range(0, 3) == 0);
         rx_busy  = ($urandom_range(0, 6) == 0);
         step();
      end
      quiet();
      rst = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
